pong_rally_sched: RTL

- Sequences one rally of the ping-pong game: serve, ball stepping, paddle hits, miss detection.
- Owns the ball-step tick timing (programmable period, speed-up on returns) and edge-detects both players' pushbuttons.
- Sits between the switch/speed logic and the match/score keeper. It gets a go pulse and reports one point_p1/point_p2 pulse per rally.

---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_tick_gen.sv | 33 +++
 rtl/pong_rally_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared rally FSM states, serve positions and default widths
// for the pong rally scheduler and its tick generator.
package pong_pkg;

  localparam int N_POS_DEF    = 10;
  localparam int PERIOD_W_DEF = 26;
  localparam int SERVE_POS_L  = 4;
  localparam int SERVE_POS_R  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RALLY,
    POINT
  } state_t;

endpackage

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: programmable-period ball-step strobe generator.
// Ports: CLK, RST (sync, high), i_clr (hold count at 0), i_period, o_tick.
module pong_tick_gen
  import pong_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_clr,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                w_last;

  // >= keeps the counter from running away if the period ever shrinks
  // below the current count.
  assign w_last = (r_cnt >= i_period - PERIOD_W'(1));
  assign o_tick = w_last && !i_clr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/pong_rally_sched.sv
// pong_rally_sched: serve, ball stepping, returns and miss detection for one
// rally. Ports: CLK, RST (sync, high), PB[1:0] (active-low buttons), go,
// serve_left, base_period -> ball_pos, ball_left, tick, hit_p1/p2,
// point_p1/p2, busy. Macro PONG_SPEEDUP_EN enables period speed-up on returns.
module pong_rally_sched
  import pong_pkg::*;
#(
  parameter int N_POS         = N_POS_DEF,
  parameter int PERIOD_W      = PERIOD_W_DEF,
  parameter int MIN_PERIOD    = 4_000_000,
  parameter int SERVE_TICKS   = 3,
  parameter int HITS_PER_STEP = 2,
  parameter int SPEED_SHIFT   = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          PB,
  input  logic                go,
  input  logic                serve_left,
  input  logic [PERIOD_W-1:0] base_period,
  output logic [N_POS-1:0]    ball_pos,
  output logic                ball_left,
  output logic                tick,
  output logic                hit_p1,
  output logic                hit_p2,
  output logic                point_p1,
  output logic                point_p2,
  output logic                busy
);

  localparam int SW = $clog2(SERVE_TICKS + 1);
  localparam logic [SW-1:0] SRV_LAST =
    SW'(SERVE_TICKS - 1);
  localparam logic [PERIOD_W-1:0] MIN_P =
    PERIOD_W'(MIN_PERIOD);

  state_t              r_state, w_state;
  logic [N_POS-1:0]    r_pos, w_pos;
  logic                r_left, w_left;
  logic [PERIOD_W-1:0] r_period, w_period;
  logic [SW-1:0]       r_srv, w_srv;
  logic                r_hit1, w_hit1;
  logic                r_hit2, w_hit2;
  logic                r_pt1, w_pt1;
  logic                r_pt2, w_pt2;
  logic [1:0]          r_s1, r_s2, r_s3;
  logic [1:0]          r_latch, w_latch;
  logic [1:0]          w_fall;
  logic                w_tick;
  logic                w_ret1, w_ret2;
  logic                w_out1, w_out2;

`ifdef PONG_SPEEDUP_EN
  localparam int HW = $clog2(HITS_PER_STEP + 1);
  localparam logic [HW-1:0] HIT_LAST =
    HW'(HITS_PER_STEP - 1);
  logic [HW-1:0]       r_hits, w_hits;
  logic [PERIOD_W-1:0] w_fast;
  assign w_fast = r_period - (r_period >> SPEED_SHIFT);
`endif

  pong_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (r_state == IDLE),
    .i_period (r_period),
    .o_tick   (w_tick)
  );

  // r_s3 is the previous synced sample: a 1->0 step is a fresh press.
  assign w_fall = r_s3 & ~r_s2;

  // Each latch is judged only against its owner's window.
  assign w_ret1 = !r_left && (r_pos[0] || r_pos[1])
                  && r_latch[0];
  assign w_ret2 = r_left
                  && (r_pos[N_POS-1] || r_pos[N_POS-2])
                  && r_latch[1];
  assign w_out1 = !r_left && r_pos[0] && !r_latch[0];
  assign w_out2 = r_left && r_pos[N_POS-1] && !r_latch[1];

  always_comb begin
    w_state  = r_state;
    w_pos    = r_pos;
    w_left   = r_left;
    w_period = r_period;
    w_srv    = r_srv;
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_pt1    = 1'b0;
    w_pt2    = 1'b0;
    w_latch  = '0;
    // Tick consumes pending presses; a press on that cycle
    // still counts for the next interval.
    if (r_state == RALLY)
      w_latch = (r_latch & ~{2{w_tick}}) | w_fall;
    unique case (r_state)
      IDLE: begin
        if (go) begin
          w_state  = SERVE;
          w_period = (base_period < MIN_P) ?
                     MIN_P : base_period;
          w_left   = serve_left;
          w_pos    = '0;
          if (serve_left) w_pos[SERVE_POS_L] = 1'b1;
          else            w_pos[SERVE_POS_R] = 1'b1;
          w_srv    = '0;
        end
      end
      SERVE: begin
        if (w_tick) begin
          if (r_srv == SRV_LAST) w_state = RALLY;
          else w_srv = r_srv + SW'(1);
        end
      end
      RALLY: begin
        if (w_tick) begin
          unique case (1'b1)
            w_ret1: begin
              w_left = 1'b1;
              w_pos  = r_pos << 1;
              w_hit1 = 1'b1;
            end
            w_ret2: begin
              w_left = 1'b0;
              w_pos  = r_pos >> 1;
              w_hit2 = 1'b1;
            end
            w_out1: begin
              w_pos   = '0;
              w_pt2   = 1'b1;
              w_state = POINT;
            end
            w_out2: begin
              w_pos   = '0;
              w_pt1   = 1'b1;
              w_state = POINT;
            end
            default: begin
              w_pos = r_left ? (r_pos << 1) : (r_pos >> 1);
            end
          endcase
        end
      end
      POINT: begin
        if (w_tick) w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
`ifdef PONG_SPEEDUP_EN
    w_hits = r_hits;
    if (r_state == IDLE && go) begin
      w_hits = '0;
    end else if (w_hit1 || w_hit2) begin
      // New period lands with the counter wrap, so it
      // governs the very next interval.
      if (r_hits == HIT_LAST) begin
        w_hits   = '0;
        w_period = (w_fast < MIN_P) ? MIN_P : w_fast;
      end else begin
        w_hits = r_hits + HW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_pos    <= '0;
      r_left   <= 1'b0;
      r_period <= MIN_P;
      r_srv    <= '0;
      r_hit1   <= 1'b0;
      r_hit2   <= 1'b0;
      r_pt1    <= 1'b0;
      r_pt2    <= 1'b0;
      r_s1     <= 2'b11;
      r_s2     <= 2'b11;
      r_s3     <= 2'b11;
      r_latch  <= 2'b00;
    end else begin
      r_state  <= w_state;
      r_pos    <= w_pos;
      r_left   <= w_left;
      r_period <= w_period;
      r_srv    <= w_srv;
      r_hit1   <= w_hit1;
      r_hit2   <= w_hit2;
      r_pt1    <= w_pt1;
      r_pt2    <= w_pt2;
      r_s1     <= PB;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_latch  <= w_latch;
    end
  end

`ifdef PONG_SPEEDUP_EN
  always_ff @(posedge CLK) begin
    if (RST) r_hits <= '0;
    else     r_hits <= w_hits;
  end
`endif

  assign ball_pos  = r_pos;
  assign ball_left = r_left;
  assign tick      = w_tick;
  assign hit_p1    = r_hit1;
  assign hit_p2    = r_hit2;
  assign point_p1  = r_pt1;
  assign point_p2  = r_pt2;
  assign busy      = (r_state != IDLE);

endmodule
